// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface memory_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (output mem_req, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_done);
  modport slave  (input mem_req, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_done);
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: drives a variable-latency data memory, stalls upstream while waiting,
// registers the MEM/WB latch. Optional MEM_ALIGN_CHECK_EN rejects odd addresses with err.
module memory_stage #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXMEM_valid,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrite,
  input  logic              EXMEM_RegWriteEN,
  input  logic [2:0]        EXMEM_DstRegNum,
  input  logic [DATA_W-1:0] EXMEM_DATA,
  input  logic [DATA_W-1:0] EXMEM_StoreData,
  memory_stage_if.master    mem,
  output logic              mem_stall,
  output logic              MEMWB_valid,
  output logic              MEMWB_RegWriteEN,
  output logic [2:0]        MEMWB_DstRegNum,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       acc, misalign, timeout, abort, is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // Gated by rst so the bus is quiet for the whole reset, not only after the edge.
    acc = ~rst & EXMEM_valid & (EXMEM_MemRead | EXMEM_MemWrite);
`ifdef MEM_ALIGN_CHECK_EN
    misalign = acc & EXMEM_DATA[0];
`else
    misalign = 1'b0;
`endif
    timeout = (state == BUSY) & acc & ~mem.mem_done & (cnt == MAX_CNT);
    abort   = misalign | timeout;
    is_load = EXMEM_MemRead & ~EXMEM_MemWrite;

    mem.mem_req   = acc & ~abort;
    mem.mem_wr    = EXMEM_MemWrite;
    mem.mem_addr  = EXMEM_DATA;
    mem.mem_wdata = EXMEM_StoreData;
    mem_stall     = acc & ~mem.mem_done & ~abort;

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_stall) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'd1;
        end
      end
      BUSY: begin
        if (mem_stall) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MEMWB_valid      <= 1'b0;
      MEMWB_RegWriteEN <= 1'b0;
      MEMWB_DstRegNum  <= '0;
      WB_DATA          <= '0;
      err              <= 1'b0;
    end else begin
      if (abort) begin
        err <= 1'b1;
      end
      // Stalled or aborted cycles retire a bubble; dst/data hold their last values.
      if (mem_stall || abort) begin
        MEMWB_valid      <= 1'b0;
        MEMWB_RegWriteEN <= 1'b0;
      end else begin
        MEMWB_valid      <= EXMEM_valid;
        MEMWB_RegWriteEN <= EXMEM_valid & EXMEM_RegWriteEN;
        MEMWB_DstRegNum  <= EXMEM_DstRegNum;
        WB_DATA          <= is_load ? mem.mem_rdata : EXMEM_DATA;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded bench for memory_stage: retirements are checked against a queue of expected WB results.
module tb_memory_stage;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 7;

  typedef struct {
    logic [2:0]  dst;
    logic        rwe;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXMEM_valid, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_RegWriteEN;
  logic [2:0]  EXMEM_DstRegNum;
  logic [15:0] EXMEM_DATA, EXMEM_StoreData;
  logic        mem_stall, MEMWB_valid, MEMWB_RegWriteEN, err;
  logic [2:0]  MEMWB_DstRegNum;
  logic [15:0] WB_DATA;

  int   n_cmp = 0;
  int   n_mis = 0;
  logic mon_en = 1'b0;
  exp_t sbq[$];
  exp_t got;

  memory_stage_if #(.DATA_W(DATA_W)) mif ();

  memory_stage #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .EXMEM_valid      (EXMEM_valid),
    .EXMEM_MemRead    (EXMEM_MemRead),
    .EXMEM_MemWrite   (EXMEM_MemWrite),
    .EXMEM_RegWriteEN (EXMEM_RegWriteEN),
    .EXMEM_DstRegNum  (EXMEM_DstRegNum),
    .EXMEM_DATA       (EXMEM_DATA),
    .EXMEM_StoreData  (EXMEM_StoreData),
    .mem              (mif),
    .mem_stall        (mem_stall),
    .MEMWB_valid      (MEMWB_valid),
    .MEMWB_RegWriteEN (MEMWB_RegWriteEN),
    .MEMWB_DstRegNum  (MEMWB_DstRegNum),
    .WB_DATA          (WB_DATA),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Every cycle with MEMWB_valid=1 is one retirement; bubbles must not write.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (MEMWB_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_mis++;
          $display("FAIL wb_unexpected: got dst=%0d data=%h, required no retirement", MEMWB_DstRegNum, WB_DATA);
        end else begin
          got = sbq.pop_front();
          if (MEMWB_DstRegNum !== got.dst || MEMWB_RegWriteEN !== got.rwe || WB_DATA !== got.data) begin
            n_mis++;
            $display("FAIL wb_data: got dst=%0d rwe=%b data=%h, required dst=%0d rwe=%b data=%h",
                     MEMWB_DstRegNum, MEMWB_RegWriteEN, WB_DATA, got.dst, got.rwe, got.data);
          end
        end
      end else if (MEMWB_valid !== 1'b0 || MEMWB_RegWriteEN !== 1'b0) begin
        n_mis++;
        $display("FAIL wb_bubble: got valid=%b rwe=%b, required 0/0", MEMWB_valid, MEMWB_RegWriteEN);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic rwe,
                       input logic [2:0] dst, input logic [15:0] data, input logic [15:0] sd);
    EXMEM_valid      = v;
    EXMEM_MemRead    = rd;
    EXMEM_MemWrite   = wr;
    EXMEM_RegWriteEN = rwe;
    EXMEM_DstRegNum  = dst;
    EXMEM_DATA       = data;
    EXMEM_StoreData  = sd;
  endtask

  task automatic push_exp(input logic [2:0] dst, input logic rwe, input logic [15:0] data);
    exp_t e;
    e.dst  = dst;
    e.rwe  = rwe;
    e.data = data;
    sbq.push_back(e);
  endtask

  // lat = cycles before mem_done (0 = same cycle); lat < 0 = memory never answers.
  task automatic do_access(input string name, input logic wr, input logic rwe, input logic [2:0] dst,
                           input logic [15:0] addr, input logic [15:0] sd, input logic [15:0] rdata,
                           input int lat);
    int last;
    last = (lat < 0) ? MAX_WAIT : lat;
    drive(1'b1, ~wr, wr, rwe, dst, addr, sd);
    if (lat >= 0) push_exp(dst, rwe, wr ? addr : rdata);
    for (int k = 0; k <= last; k++) begin
      logic xr, xs;
      mif.mem_done  = (k == lat);
      mif.mem_rdata = (k == lat) ? rdata : 16'($urandom);
      xr = (lat < 0) ? (k < MAX_WAIT) : 1'b1;
      xs = (lat < 0) ? (k < MAX_WAIT) : (k < lat);
      #1;
      n_cmp++;
      if (mif.mem_req !== xr) begin
        n_mis++;
        $display("FAIL %s_req: cycle %0d got %b required %b", name, k, mif.mem_req, xr);
      end
      n_cmp++;
      if (mem_stall !== xs) begin
        n_mis++;
        $display("FAIL %s_stall: cycle %0d got %b required %b", name, k, mem_stall, xs);
      end
      if (xr) begin
        n_cmp++;
        if ({mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {wr, addr, sd}) begin
          n_mis++;
          $display("FAIL %s_bus: cycle %0d got wr=%b addr=%h wdata=%h required wr=%b addr=%h wdata=%h",
                   name, k, mif.mem_wr, mif.mem_addr, mif.mem_wdata, wr, addr, sd);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (MEMWB_valid !== 1'b0) begin
          n_mis++;
          $display("FAIL %s_stall_bubble: cycle %0d got MEMWB_valid=%b required 0", name, k, MEMWB_valid);
        end
      end
      tick();
    end
    mif.mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    mif.mem_done  = 1'b0;
    mif.mem_rdata = 16'h0;
    tick();
    tick();
    n_cmp++;
    if (mif.mem_req !== 1'b0 || mem_stall !== 1'b0 || err !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: got req=%b stall=%b err=%b required 0/0/0", mif.mem_req, mem_stall, err);
    end
    n_cmp++;
    if ({MEMWB_valid, MEMWB_RegWriteEN, MEMWB_DstRegNum, WB_DATA} !== '0) begin
      n_mis++;
      $display("FAIL reset_memwb: got valid=%b rwe=%b dst=%0d data=%h required all 0",
               MEMWB_valid, MEMWB_RegWriteEN, MEMWB_DstRegNum, WB_DATA);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_alu();
    logic [15:0] d;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'hFFFF);
    push_exp(3'd3, 1'b1, 16'h1234);
    #1;
    n_cmp++;
    if (mif.mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_mis++;
      $display("FAIL alu_req: got req=%b stall=%b required 0/0", mif.mem_req, mem_stall);
    end
    tick();
    n_cmp++;
    if (WB_DATA !== 16'h1234 || MEMWB_RegWriteEN !== 1'b1 || MEMWB_DstRegNum !== 3'd3) begin
      n_mis++;
      $display("FAIL alu_wb: got data=%h rwe=%b dst=%0d required 1234/1/3", WB_DATA, MEMWB_RegWriteEN, MEMWB_DstRegNum);
    end
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      drive(1'b1, 1'b0, 1'b0, i[0], 3'(i), d, 16'h0);
      push_exp(3'(i), i[0], d);
      #1;
      n_cmp++;
      if (mif.mem_req !== 1'b0) begin
        n_mis++;
        $display("FAIL alu_seq_req: op %0d got %b required 0", i, mif.mem_req);
      end
      tick();
    end
    // Bubble carrying RegWriteEN=1 must retire with RegWriteEN forced low.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 16'hDEAD, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_load_zero_wait();
    do_access("ld0", 1'b0, 1'b1, 3'd5, 16'h0040, 16'h0, 16'hBEEF, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    n_cmp++;
    if (MEMWB_valid !== 1'b1 || WB_DATA !== 16'hBEEF) begin
      n_mis++;
      $display("FAIL ld0_wb: got valid=%b data=%h required 1/BEEF", MEMWB_valid, WB_DATA);
    end
    tick();
  endtask

  task automatic test_store_wait();
    do_access("st3", 1'b1, 1'b0, 3'd2, 16'h0010, 16'hA5A5, 16'h0, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    n_cmp++;
    if (MEMWB_valid !== 1'b1 || MEMWB_RegWriteEN !== 1'b0) begin
      n_mis++;
      $display("FAIL st3_wb: got valid=%b rwe=%b required 1/0", MEMWB_valid, MEMWB_RegWriteEN);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_access("tmo", 1'b0, 1'b1, 3'd4, 16'h0080, 16'h0, 16'h0, -1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 16'h5A5A, 16'h0);
    push_exp(3'd6, 1'b1, 16'h5A5A);
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++;
      $display("FAIL tmo_err: got %b required 1", err);
    end
    tick();
    // Stray mem_done with no request outstanding must be ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    mif.mem_done  = 1'b1;
    mif.mem_rdata = 16'h7777;
    #1;
    n_cmp++;
    if (mif.mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_mis++;
      $display("FAIL stray_done: got req=%b stall=%b required 0/0", mif.mem_req, mem_stall);
    end
    tick();
    mif.mem_done = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++;
      $display("FAIL tmo_err_sticky: got %b required 1", err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_access("b2b_a", 1'b0, 1'b1, 3'd1, 16'h0100, 16'h0, 16'h1111, 0);
    do_access("b2b_b", 1'b1, 1'b0, 3'd2, 16'h0102, 16'h2222, 16'h0, 2);
    do_access("b2b_c", 1'b0, 1'b1, 3'd3, 16'h0104, 16'h0, 16'h3333, 1);
    for (int i = 0; i < 8; i++) begin
      logic        w;
      int          lat;
      logic [15:0] a;
      w   = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      a   = 16'($urandom) & 16'hFFFE;
      do_access("b2b_rnd", w, ~w, 3'(i), a, 16'($urandom), 16'($urandom), lat);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_rst_mid_access();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0200, 16'h0);
    mif.mem_done = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (mem_stall !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_busy_stall: got %b required 1", mem_stall);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (mif.mem_req !== 1'b0 || mem_stall !== 1'b0 || err !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_mid_ctrl: got req=%b stall=%b err=%b required 0/0/0", mif.mem_req, mem_stall, err);
    end
    n_cmp++;
    if ({MEMWB_valid, MEMWB_RegWriteEN, MEMWB_DstRegNum, WB_DATA} !== '0) begin
      n_mis++;
      $display("FAIL rst_mid_memwb: got valid=%b rwe=%b dst=%0d data=%h required all 0",
               MEMWB_valid, MEMWB_RegWriteEN, MEMWB_DstRegNum, WB_DATA);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_align();
    n_cmp++;
    if (err !== 1'b0) begin
      n_mis++;
      $display("FAIL align_pre_err: got %b required 0", err);
    end
`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h0003, 16'h0);
    mif.mem_done = 1'b0;
    #1;
    n_cmp++;
    if (mif.mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_mis++;
      $display("FAIL align_req: got req=%b stall=%b required 0/0", mif.mem_req, mem_stall);
    end
    tick();
    n_cmp++;
    if (err !== 1'b1 || MEMWB_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL align_err: got err=%b valid=%b required 1/0", err, MEMWB_valid);
    end
`else
    do_access("unaligned", 1'b0, 1'b1, 3'd7, 16'h0003, 16'h0, 16'hC0DE, 0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    tick();
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_store_wait();
        test_timeout();
        test_back_to_back();
        test_rst_mid_access();
        test_align();
        n_cmp++;
        if (sbq.size() != 0) begin
          n_mis++;
          $display("FAIL sb_drain: got %0d pending retirements, required 0", sbq.size());
        end
      end
      begin
        #100000;
        n_cmp++;
        n_mis++;
        $display("FAIL watchdog: got time limit expired, required test sequence completion");
      end
    join_any
    disable fork;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
